// File: rtl/al_accel_pkg.sv
// al_accel_pkg -- shared constants for the accumulate/requantize block.
//   * FSM state encoding (IDLE, ACC, MUL, RND, OUT)
//   * datapath widths: 32-bit accumulator, 8-bit data, 64-bit product
//   * Q31 fixed-point shift constant
//   * acc_add(): one accumulate step. It saturates when AL_ACCEL_ACC_SAT_EN
//     is defined and wraps modulo 2^32 otherwise.
package al_accel_pkg;

  localparam int ACC_W     = 32;
  localparam int DATA_W    = 8;
  localparam int PROD_W    = 64;
  localparam int Q31_SHIFT = 31;

  localparam int ST_W = 3;
  localparam logic [ST_W-1:0] ST_IDLE = 3'd0;
  localparam logic [ST_W-1:0] ST_ACC  = 3'd1;
  localparam logic [ST_W-1:0] ST_MUL  = 3'd2;
  localparam logic [ST_W-1:0] ST_RND  = 3'd3;
  localparam logic [ST_W-1:0] ST_OUT  = 3'd4;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  function automatic logic signed [ACC_W-1:0] acc_add(
    input logic signed [ACC_W-1:0] a,
    input logic signed [ACC_W-1:0] b
  );
`ifdef AL_ACCEL_ACC_SAT_EN
    logic signed [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    // The sign bit and the carry bit differ only when the sum overflowed.
    if (s[ACC_W] != s[ACC_W-1]) return s[ACC_W] ? ACC_MIN : ACC_MAX;
    return s[ACC_W-1:0];
`else
    return a + b;
`endif
  endfunction

endpackage

// File: rtl/al_accel_requant.sv
// al_accel_requant -- the MUL / RND / clamp datapath for one output pixel.
//   clk, resetn            : clock, synchronous active-low reset
//   mul_en, rnd_en, out_en : one-hot stage strobes from the controlling FSM
//   acc                    : final signed accumulator value
//   mult, shift            : Q31 multiplier and extra right shift (latched)
//   offset                 : output zero point (latched)
//   act_min, act_max       : clamp bounds (latched)
//   out_data, out_vld      : int8 result (held until next OUT), 1-cycle valid
module al_accel_requant
  import al_accel_pkg::*;
(
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     mul_en,
  input  logic                     rnd_en,
  input  logic                     out_en,
  input  logic signed [ACC_W-1:0]  acc,
  input  logic signed [ACC_W-1:0]  mult,
  input  logic [4:0]               shift,
  input  logic signed [DATA_W-1:0] offset,
  input  logic signed [DATA_W-1:0] act_min,
  input  logic signed [DATA_W-1:0] act_max,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_vld
);

  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] v;

  logic        [5:0]        s;
  logic signed [PROD_W-1:0] acc_ext, mult_ext, round_c, v_next;
  logic signed [PROD_W-1:0] off_ext, min_ext, max_ext;
  logic signed [DATA_W-1:0] clamped;

  // NOTE: every always_comb output gets a default assignment first, so no
  // path through the block can leave a value unassigned and infer a latch.
  always_comb begin
    acc_ext  = {{(PROD_W-ACC_W){acc[ACC_W-1]}}, acc};
    mult_ext = {{(PROD_W-ACC_W){mult[ACC_W-1]}}, mult};
    off_ext  = {{(PROD_W-DATA_W){offset[DATA_W-1]}}, offset};
    min_ext  = {{(PROD_W-DATA_W){act_min[DATA_W-1]}}, act_min};
    max_ext  = {{(PROD_W-DATA_W){act_max[DATA_W-1]}}, act_max};
    s        = 6'(Q31_SHIFT) + {1'b0, shift};
    // s is at least 31, so s-1 never underflows; this adds half an LSB.
    round_c  = 64'sd1 <<< (s - 6'd1);
    v_next   = ((prod + round_c) >>> s) + off_ext;

    // min(max(v, act_min), act_max): if the bounds are inverted, act_max wins.
    clamped = v[DATA_W-1:0];
    if (v < min_ext)      clamped = (act_min > act_max) ? act_max : act_min;
    else if (v > max_ext) clamped = act_max;
  end

  // NOTE: reset is sampled synchronously inside the clocked block, and all
  // state is updated with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      prod     <= '0;
      v        <= '0;
      out_data <= '0;
      out_vld  <= 1'b0;
    end else begin
      out_vld <= out_en;
      if (mul_en) prod     <= acc_ext * mult_ext;
      if (rnd_en) v        <= v_next;
      if (out_en) out_data <= clamped;
    end
  end

endmodule

// File: rtl/al_accel_acc_quant.sv
// al_accel_acc_quant -- accumulates cfg_num_ch PU partial sums onto a bias,
// then requantizes the result to int8 (Q31 multiply, rounding shift, zero
// point, clamp).
//   clk, resetn       : clock, synchronous active-low reset
//   start             : 1-cycle pulse in IDLE; latches cfg_* and starts a pixel
//   cfg_num_ch        : number of partial sums to accumulate (0 allowed)
//   cfg_bias          : initial accumulator value
//   cfg_mult/shift    : Q31 multiplier and extra right shift
//   cfg_out_offset    : output zero point
//   cfg_act_min/max   : clamp bounds
//   acc_in, acc_vld   : partial sum stream from the PU
//   out_data, out_vld : int8 result and its 1-cycle valid strobe
//   busy              : high outside IDLE
//   drop_err          : sticky flag; an acc_vld arrived outside ACC
// Build option: AL_ACCEL_ACC_SAT_EN selects a saturating accumulator
// (the default build wraps).
module al_accel_acc_quant
  import al_accel_pkg::*;
(
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     start,
  input  logic [15:0]              cfg_num_ch,
  input  logic signed [ACC_W-1:0]  cfg_bias,
  input  logic signed [ACC_W-1:0]  cfg_mult,
  input  logic [4:0]               cfg_shift,
  input  logic signed [DATA_W-1:0] cfg_out_offset,
  input  logic signed [DATA_W-1:0] cfg_act_min,
  input  logic signed [DATA_W-1:0] cfg_act_max,
  input  logic signed [ACC_W-1:0]  acc_in,
  input  logic                     acc_vld,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_vld,
  output logic                     busy,
  output logic                     drop_err
);

  logic [ST_W-1:0]          state;
  logic signed [ACC_W-1:0]  acc;
  logic [15:0]              cnt;
  logic [15:0]              num_ch_q;
  logic signed [ACC_W-1:0]  mult_q;
  logic [4:0]               shift_q;
  logic signed [DATA_W-1:0] off_q, min_q, max_q;

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      acc      <= '0;
      cnt      <= '0;
      drop_err <= 1'b0;
      num_ch_q <= '0;
      mult_q   <= '0;
      shift_q  <= '0;
      off_q    <= '0;
      min_q    <= '0;
      max_q    <= '0;
    end else begin
      // A dropped acc_vld in the start cycle wins over the clear from start.
      if (acc_vld && state != ST_ACC)        drop_err <= 1'b1;
      else if (start && state == ST_IDLE)    drop_err <= 1'b0;

      case (state)
        ST_IDLE: if (start) begin
          num_ch_q <= cfg_num_ch;
          mult_q   <= cfg_mult;
          shift_q  <= cfg_shift;
          off_q    <= cfg_out_offset;
          min_q    <= cfg_act_min;
          max_q    <= cfg_act_max;
          acc      <= cfg_bias;
          cnt      <= '0;
          state    <= (cfg_num_ch != 16'd0) ? ST_ACC : ST_MUL;
        end
        ST_ACC: if (acc_vld) begin
          acc <= acc_add(acc, acc_in);
          cnt <= cnt + 16'd1;
          if (cnt + 16'd1 == num_ch_q) state <= ST_MUL;
        end
        ST_MUL:  state <= ST_RND;
        ST_RND:  state <= ST_OUT;
        ST_OUT:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  al_accel_requant u_requant (
    .clk      (clk),
    .resetn   (resetn),
    .mul_en   (state == ST_MUL),
    .rnd_en   (state == ST_RND),
    .out_en   (state == ST_OUT),
    .acc      (acc),
    .mult     (mult_q),
    .shift    (shift_q),
    .offset   (off_q),
    .act_min  (min_q),
    .act_max  (max_q),
    .out_data (out_data),
    .out_vld  (out_vld)
  );

endmodule

// File: tb/tb_al_accel_acc_quant.sv
// Self-checking bench for al_accel_acc_quant: directed cases plus randomized
// pixels scored against a plain-arithmetic reference model.
module tb_al_accel_acc_quant;

  logic              clk = 1'b0;
  logic              resetn;
  logic              start;
  logic [15:0]       cfg_num_ch;
  logic signed [31:0] cfg_bias, cfg_mult;
  logic [4:0]        cfg_shift;
  logic signed [7:0] cfg_out_offset, cfg_act_min, cfg_act_max;
  logic signed [31:0] acc_in;
  logic              acc_vld;
  logic signed [7:0] out_data;
  logic              out_vld, busy, drop_err;

  always #5 clk = ~clk;

  al_accel_acc_quant dut (
    .clk            (clk),
    .resetn         (resetn),
    .start          (start),
    .cfg_num_ch     (cfg_num_ch),
    .cfg_bias       (cfg_bias),
    .cfg_mult       (cfg_mult),
    .cfg_shift      (cfg_shift),
    .cfg_out_offset (cfg_out_offset),
    .cfg_act_min    (cfg_act_min),
    .cfg_act_max    (cfg_act_max),
    .acc_in         (acc_in),
    .acc_vld        (acc_vld),
    .out_data       (out_data),
    .out_vld        (out_vld),
    .busy           (busy),
    .drop_err       (drop_err)
  );

  int n_cmp = 0;
  int n_err = 0;
  int ins[16];

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: accumulate with plain integers, then requantize by the formula.
  function automatic longint ref_pixel(input int nch, input int bias,
                                       input int mult, input int shift,
                                       input int off, input int mn, input int mx);
    longint a, prod, v;
    logic signed [31:0] w;
    int s;
    a = bias;
    for (int i = 0; i < nch; i++) begin
      a = a + longint'(ins[i]);
`ifdef AL_ACCEL_ACC_SAT_EN
      if (a > 64'sd2147483647)  a = 64'sd2147483647;
      if (a < -64'sd2147483648) a = -64'sd2147483648;
`else
      w = a[31:0];
      a = w;
`endif
    end
    prod = a * longint'(mult);
    s = 31 + shift;
    v = ((prod + (64'sd1 <<< (s - 1))) >>> s) + off;
    if (v < mn) v = mn;
    if (v > mx) v = mx;
    return v;
  endfunction

  function automatic void rand_cfg();
    cfg_num_ch     = 16'($urandom);
    cfg_bias       = $urandom;
    cfg_mult       = $urandom;
    cfg_shift      = 5'($urandom);
    cfg_out_offset = 8'($urandom);
    cfg_act_min    = 8'($urandom);
    cfg_act_max    = 8'($urandom);
  endfunction

  // Runs one pixel using ins[0..nch-1]. stray: also pulse acc_vld in the start
  // cycle (must be dropped). poke: pulse start with junk cfg while in ACC.
  task automatic run_pixel(input string tag, input int nch, input int bias,
                           input int mult, input int shift, input int off,
                           input int mn, input int mx, input bit stray,
                           input bit poke, input longint exp_data);
    int lat;
    @(negedge clk);
    start          = 1'b1;
    cfg_num_ch     = 16'(nch);
    cfg_bias       = bias;
    cfg_mult       = mult;
    cfg_shift      = 5'(shift);
    cfg_out_offset = 8'(off);
    cfg_act_min    = 8'(mn);
    cfg_act_max    = 8'(mx);
    acc_vld        = stray;
    acc_in         = $urandom;
    @(negedge clk);
    start   = 1'b0;
    acc_vld = 1'b0;
    rand_cfg();
    check({tag, ".busy"}, 64'(busy), 64'd1);
    check({tag, ".drop_start"}, 64'(drop_err), 64'(stray));
    for (int i = 0; i < nch; i++) begin
      repeat ($urandom_range(0, 2)) begin
        start = poke && ($urandom_range(0, 1) == 1);
        @(negedge clk);
        start = 1'b0;
        rand_cfg();
      end
      acc_vld = 1'b1;
      acc_in  = ins[i];
      @(posedge clk);
      #1 acc_vld = 1'b0;
      if (i != nch - 1) @(negedge clk);
    end
    lat = -1;
    for (int j = 1; j <= 8; j++) begin
      @(posedge clk);
      #1;
      if (out_vld) begin
        lat = j;
        break;
      end
    end
    check({tag, ".latency"}, 64'(lat), 64'd3);
    check({tag, ".data"}, 64'(out_data), exp_data);
    @(posedge clk);
    #1;
    check({tag, ".vld_pulse"}, 64'(out_vld), 64'd0);
    check({tag, ".hold"}, 64'(out_data), exp_data);
    check({tag, ".idle"}, 64'(busy), 64'd0);
    check({tag, ".drop_end"}, 64'(drop_err), 64'(stray));
  endtask

  initial begin
    longint e;
    int nch, bias, mult, shift, off, mn, mx;
    resetn = 1'b0; start = 1'b0; acc_vld = 1'b0; acc_in = '0;
    rand_cfg();
    repeat (2) @(negedge clk);
    check("rst.data", 64'(out_data), 64'd0);
    check("rst.vld", 64'(out_vld), 64'd0);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.drop", 64'(drop_err), 64'd0);
    resetn = 1'b1;

    // Basic pixel: 10 + 3*45 = 145 -> 73, minus 128.
    ins[0] = 45; ins[1] = 45; ins[2] = 45;
    run_pixel("basic", 3, 10, 32'h4000_0000, 0, -128, -128, 127, 0, 0, -55);

    // Upper clamp.
    ins[0] = 1000;
    run_pixel("clamp_hi", 1, 0, 32'h4000_0000, 0, 0, -128, 127, 0, 0, 127);

    // Accumulator overflow: saturate vs wrap.
    ins[0] = 32'h7FFF_FFFF; ins[1] = 1;
`ifdef AL_ACCEL_ACC_SAT_EN
    run_pixel("ovf", 2, 0, 32'h4000_0000, 0, 0, -128, 127, 0, 0, 127);
`else
    run_pixel("ovf", 2, 0, 32'h4000_0000, 0, 0, -128, 127, 0, 0, -128);
`endif

    // Zero channels: -20 * 0.5 / 2 = -5 (floor with rounding), +3.
    run_pixel("zero_ch", 0, -20, 32'h4000_0000, 1, 3, -128, 127, 0, 0, -2);

    // acc_vld in IDLE is dropped and flagged; no output appears.
    @(negedge clk);
    acc_vld = 1'b1; acc_in = 32'd500;
    @(negedge clk);
    acc_vld = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_drop.flag", 64'(drop_err), 64'd1);
    check("idle_drop.novld", 64'(out_vld), 64'd0);
    check("idle_drop.busy", 64'(busy), 64'd0);
    // Next start clears the flag (checked inside as drop_start = 0).
    ins[0] = 45; ins[1] = 45; ins[2] = 45;
    run_pixel("after_drop", 3, 10, 32'h4000_0000, 0, -128, -128, 127, 0, 0, -55);

    // acc_vld coincident with start is dropped and sets the flag.
    ins[0] = 1000;
    run_pixel("stray", 1, 0, 32'h4000_0000, 0, 0, -128, 127, 1, 0, 127);

    // Reset mid-pixel after 2 of 3 inputs.
    @(negedge clk);
    start = 1'b1; cfg_num_ch = 16'd3; cfg_bias = 10; cfg_mult = 32'h4000_0000;
    cfg_shift = 5'd0; cfg_out_offset = -8'sd128; cfg_act_min = -8'sd128;
    cfg_act_max = 8'sd127;
    @(negedge clk);
    start = 1'b0;
    repeat (2) begin
      acc_vld = 1'b1; acc_in = 45;
      @(negedge clk);
    end
    acc_vld = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check("midrst.data", 64'(out_data), 64'd0);
    check("midrst.vld", 64'(out_vld), 64'd0);
    check("midrst.busy", 64'(busy), 64'd0);
    check("midrst.drop", 64'(drop_err), 64'd0);
    repeat (4) @(negedge clk);
    check("midrst.quiet", 64'(out_vld), 64'd0);
    ins[0] = 45; ins[1] = 45; ins[2] = 45;
    run_pixel("post_rst", 3, 10, 32'h4000_0000, 0, -128, -128, 127, 0, 0, -55);

    // Randomized pixels, some with start pokes during ACC.
    for (int r = 0; r < 40; r++) begin
      nch = $urandom_range(0, 6);
      for (int i = 0; i < nch; i++) begin
        ins[i] = ($urandom_range(0, 3) == 0) ? int'($urandom)
                                             : $urandom_range(0, 2000) - 1000;
      end
      bias  = ($urandom_range(0, 3) == 0) ? int'($urandom)
                                          : $urandom_range(0, 2000) - 1000;
      mult  = $urandom;
      shift = $urandom_range(0, 31);
      off   = $urandom_range(0, 255) - 128;
      mn    = $urandom_range(0, 255) - 128;
      mx    = $urandom_range(0, 255) - 128;
      if (mn > mx && $urandom_range(0, 3) != 0) begin
        int t;
        t = mn; mn = mx; mx = t;
      end
      e = ref_pixel(nch, bias, mult, shift, off, mn, mx);
      if (mn > mx) e = mx;
      run_pixel($sformatf("rnd%0d", r), nch, bias, mult, shift, off, mn, mx,
                bit'($urandom_range(0, 4) == 0), bit'($urandom_range(0, 1)), e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/al_accel_acc_quant.md
AL_ACCEL_ACC_QUANT -- requirements
Module: al_accel_acc_quant

Interface
REQ-001 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-002 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port start  input  1  one-cycle pulse; latches cfg_* and begins one output pixel.
REQ-004 SHALL have port cfg_num_ch  input  16  unsigned count of PU partial sums to accumulate.
REQ-005 SHALL have port cfg_bias  input  32  signed bias; initial accumulator value.
REQ-006 SHALL have port cfg_mult  input  32  signed Q31 requant multiplier.
REQ-007 SHALL have port cfg_shift  input  5  unsigned extra right shift, 0..31.
REQ-008 SHALL have port cfg_out_offset  input  8  signed output zero point.
REQ-009 SHALL have port cfg_act_min / cfg_act_max  input  8 each  signed clamp bounds.
REQ-010 SHALL have port acc_in  input  32  signed PU sum (driven by pu_odo).
REQ-011 SHALL have port acc_vld  input  1  acc_in valid (driven by PU rdy).
REQ-012 SHALL have port out_data  output  8  signed requantized int8 result.
REQ-013 SHALL have port out_vld  output  1  one-cycle pulse, out_data valid.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port drop_err  output  1  sticky; an acc_vld was ignored.

Function
REQ-016 FSM states SHALL be IDLE, ACC, MUL, RND, OUT.
REQ-017 IDLE: start SHALL latch all cfg_*, load acc=cfg_bias, cnt=0; go ACC if cfg_num_ch!=0, else MUL.
REQ-018 ACC: each acc_vld SHALL add acc_in to acc and increment cnt; on cnt reaching cfg_num_ch go MUL.
REQ-019 MUL SHALL register prod = acc * mult_latched as signed 64-bit.
REQ-020 RND SHALL register v = ((prod + 2^(s-1)) >>> s) + out_offset, where s = 31 + shift_latched; arithmetic shift, 64-bit intermediate.
REQ-021 OUT SHALL drive out_data = min(max(v, act_min), act_max), assert out_vld for exactly one cycle, return IDLE.
REQ-022 Latency: out_vld SHALL be high in the cycle after the 3rd rising edge following the edge that samples the last acc_vld.
REQ-023 acc_vld outside ACC (including the start cycle) SHALL be dropped and SHALL set drop_err.
REQ-024 start outside IDLE SHALL be ignored; a start in IDLE SHALL clear drop_err.
REQ-025 out_data SHALL hold its value until the next OUT.

Reset
REQ-026 resetn low at any edge SHALL force IDLE, acc=0, cnt=0, out_data=0, out_vld=0, busy=0, drop_err=0, aborting any in-flight pixel.

Configuration
REQ-027 With AL_ACCEL_ACC_SAT_EN defined, each accumulate SHALL saturate to [-2^31, 2^31-1].
REQ-028 Without AL_ACCEL_ACC_SAT_EN, accumulation SHALL wrap modulo 2^32.

Structure
REQ-029 al_accel_pkg SHALL hold the FSM state encoding, the widths (32 acc, 8 data, 64 prod) and the Q31 constant 31.
REQ-030 The MUL/RND/clamp datapath SHALL be a sub-module al_accel_requant; the FSM, counter and accumulator stay in the top.

Verification
REQ-031 num_ch=3, bias=10, acc_in 45,45,45, mult=2^30, shift=0, offset=-128, clamp [-128,127] -> out_data=-55, out_vld 3 cycles after last acc_vld.
REQ-032 num_ch=1, bias=0, acc_in=1000, mult=2^30, shift=0, offset=0, clamp [-128,127] -> out_data=127 (clamped).
REQ-033 num_ch=2, bias=0, acc_in 0x7FFFFFFF then 1, mult=2^30, shift=0, offset=0 -> out_data=127 with AL_ACCEL_ACC_SAT_EN, -128 without.
REQ-034 num_ch=0, bias=-20, mult=2^30, shift=1, offset=3 -> out_data=-2, no acc_vld consumed.
REQ-035 acc_vld in IDLE -> drop_err=1, no out_vld; next start -> drop_err=0.
REQ-036 resetn low for one cycle after 2 of 3 inputs -> all outputs 0, IDLE; a fresh REQ-031 run then gives -55.
